// File: rtl/exec_alu_branch_unit_pkg.sv
// Shared encodings for the execute-stage ALU/branch slice.
// Op codes, addx selects, flag bit positions and branch condition codes.
package exec_alu_branch_unit_pkg;

    localparam int W_OPR    = 32;
    localparam int ADDR     = 32;
    localparam int W_SELECT = 4;
    localparam int W_CC     = 4;
    localparam int W_FLAGS  = 4;

    typedef enum logic [1:0] {
        OP_NOP    = 2'b00,
        OP_ADDX   = 2'b01,
        OP_ABSX   = 2'b10,
        OP_BRANCH = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        SEL_ADD = 2'b00,
        SEL_SUB = 2'b01,
        SEL_ADC = 2'b10,
        SEL_SBB = 2'b11
    } addx_sel_e;

    localparam int FLG_C = 0;
    localparam int FLG_Z = 1;
    localparam int FLG_S = 2;
    localparam int FLG_V = 3;

    localparam logic [W_CC-1:0] CC_AL  = 4'h0;
    localparam logic [W_CC-1:0] CC_EQ  = 4'h1;
    localparam logic [W_CC-1:0] CC_NE  = 4'h2;
    localparam logic [W_CC-1:0] CC_CS  = 4'h3;
    localparam logic [W_CC-1:0] CC_CC  = 4'h4;
    localparam logic [W_CC-1:0] CC_MI  = 4'h5;
    localparam logic [W_CC-1:0] CC_PL  = 4'h6;
    localparam logic [W_CC-1:0] CC_VS  = 4'h7;
    localparam logic [W_CC-1:0] CC_VC  = 4'h8;
    localparam logic [W_CC-1:0] CC_LT  = 4'h9;
    localparam logic [W_CC-1:0] CC_GE  = 4'hA;
    localparam logic [W_CC-1:0] CC_LE  = 4'hB;
    localparam logic [W_CC-1:0] CC_GT  = 4'hC;
    localparam logic [W_CC-1:0] CC_LS  = 4'hD;
    localparam logic [W_CC-1:0] CC_HI  = 4'hE;
    localparam logic [W_CC-1:0] CC_NV  = 4'hF;

endpackage

// File: rtl/exec_alu_branch_unit_if.sv
// Execute-stage bus: decoded instruction operands in, ALU result,
// flags and branch redirect out.
interface exec_alu_branch_unit_if;
    import exec_alu_branch_unit_pkg::*;

    logic                v_i;
    logic                stall_i;
    logic [1:0]          op_i;
    logic [W_SELECT-1:0] select_i;
    logic [W_OPR-1:0]    opr0_i;
    logic [W_OPR-1:0]    opr1_i;
    logic [ADDR-1:0]     pc_i;
    logic [W_CC-1:0]     cc_i;
    logic [W_OPR-1:0]    result_o;
    logic [W_FLAGS-1:0]  flags_next_o;
    logic [W_FLAGS-1:0]  flags_o;
    logic                branch_o;
    logic [ADDR-1:0]     branch_addr_o;

    modport master (
        output v_i, stall_i, op_i, select_i,
        output opr0_i, opr1_i, pc_i, cc_i,
        input  result_o, flags_next_o, flags_o,
        input  branch_o, branch_addr_o
    );

    modport slave (
        input  v_i, stall_i, op_i, select_i,
        input  opr0_i, opr1_i, pc_i, cc_i,
        output result_o, flags_next_o, flags_o,
        output branch_o, branch_addr_o
    );

endinterface

// File: rtl/exec_cond_eval.sv
// Branch condition evaluation from a condition code and the flags.
module exec_cond_eval
    import exec_alu_branch_unit_pkg::*;
(
    input  logic [W_CC-1:0]    i_cc,
    input  logic [W_FLAGS-1:0] i_flags,
    output logic               o_cond
);

    logic w_c, w_z, w_s, w_v, w_lt;

    assign w_c  = i_flags[FLG_C];
    assign w_z  = i_flags[FLG_Z];
    assign w_s  = i_flags[FLG_S];
    assign w_v  = i_flags[FLG_V];
    assign w_lt = w_s ^ w_v;

    always_comb begin
        o_cond = 1'b0;
        unique case (i_cc)
            CC_AL: o_cond = 1'b1;
            CC_EQ: o_cond = w_z;
            CC_NE: o_cond = ~w_z;
            CC_CS: o_cond = w_c;
            CC_CC: o_cond = ~w_c;
            CC_MI: o_cond = w_s;
            CC_PL: o_cond = ~w_s;
            CC_VS: o_cond = w_v;
            CC_VC: o_cond = ~w_v;
            CC_LT: o_cond = w_lt;
            CC_GE: o_cond = ~w_lt;
            CC_LE: o_cond = w_z | w_lt;
            CC_GT: o_cond = ~w_z & ~w_lt;
            CC_LS: o_cond = w_c | w_z;
            CC_HI: o_cond = ~w_c & ~w_z;
            CC_NV: o_cond = 1'b0;
        endcase
    end

endmodule

// File: rtl/exec_alu_branch_unit.sv
// Execute slice: add/sub with carry, absolute value, branch resolution,
// and the architectural flags register.
module exec_alu_branch_unit
    import exec_alu_branch_unit_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    exec_alu_branch_unit_if.slave bus
);

    localparam int MSB = W_OPR - 1;

    logic [W_FLAGS-1:0] r_flags;
    logic [W_FLAGS-1:0] w_flags_next;
    logic [W_OPR-1:0]   w_result;
    logic [W_OPR-1:0]   w_abs;
    logic [W_OPR:0]     w_sum;
    logic [W_OPR:0]     w_cin;
    logic               w_sub;
    logic               w_arith;
    logic               w_fire;
    logic               w_cond;
    logic               w_unused;

    assign w_sub   = bus.select_i[0];
    assign w_cin   = {{W_OPR{1'b0}}, bus.select_i[1] & r_flags[FLG_C]};
    assign w_abs   = bus.opr1_i[MSB] ? (~bus.opr1_i + W_OPR'(1))
                                     : bus.opr1_i;
    assign w_arith = (bus.op_i == OP_ADDX) || (bus.op_i == OP_ABSX);
    assign w_fire  = bus.v_i & ~bus.stall_i;

    always_comb begin
        w_result     = '0;
        w_flags_next = '0;
        w_sum        = '0;
        unique case (op_e'(bus.op_i))
            OP_ADDX: begin
                // 33-bit add/sub: top bit is carry-out or borrow.
                if (w_sub)
                    w_sum = {1'b0, bus.opr0_i} - {1'b0, bus.opr1_i} - w_cin;
                else
                    w_sum = {1'b0, bus.opr0_i} + {1'b0, bus.opr1_i} + w_cin;
                w_result = w_sum[MSB:0];
                w_flags_next[FLG_C] = w_sum[W_OPR];
                w_flags_next[FLG_V] =
                    ((bus.opr0_i[MSB] ^ bus.opr1_i[MSB]) == w_sub) &&
                    (w_result[MSB] != bus.opr0_i[MSB]);
            end
            OP_ABSX: begin
                w_result = w_abs;
                w_flags_next[FLG_V] = (bus.opr1_i == {1'b1, {MSB{1'b0}}});
            end
            default: ;
        endcase
        w_flags_next[FLG_Z] = w_arith && (w_result == '0);
        w_flags_next[FLG_S] = w_result[MSB];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_flags <= '0;
        else if (w_fire && w_arith)
            r_flags <= w_flags_next;
    end

    exec_cond_eval u_cond (
        .i_cc    (bus.cc_i),
        .i_flags (r_flags),
        .o_cond  (w_cond)
    );

    assign bus.result_o      = w_result;
    assign bus.flags_next_o  = w_flags_next;
    assign bus.flags_o       = r_flags;
    assign bus.branch_o      = w_fire && (bus.op_i == OP_BRANCH) && w_cond;
    assign bus.branch_addr_o = bus.select_i[0]
                             ? bus.pc_i + bus.opr1_i[ADDR-1:0]
                             : bus.opr1_i[ADDR-1:0];

    assign w_unused = ^bus.select_i[W_SELECT-1:2];

endmodule

// File: tb/tb_exec_alu_branch_unit.sv
// Scoreboard bench for exec_alu_branch_unit: directed cases then random.
module tb_exec_alu_branch_unit;

    logic clk = 1'b0;
    logic reset = 1'b1;

    exec_alu_branch_unit_if bus ();

    exec_alu_branch_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic [3:0]  fn;
        logic [3:0]  fo;
        logic        br;
        logic [31:0] ba;
    } exp_t;

    exp_t sb_q[$];
    int checks = 0;
    int errors = 0;
    bit [3:0] m_flags = 4'h0;

    function automatic bit cond_of(input bit [3:0] cc, input bit [3:0] f);
        bit c, z, s, v;
        c = f[0]; z = f[1]; s = f[2]; v = f[3];
        case (cc)
            4'h0: return 1'b1;
            4'h1: return z;
            4'h2: return !z;
            4'h3: return c;
            4'h4: return !c;
            4'h5: return s;
            4'h6: return !s;
            4'h7: return v;
            4'h8: return !v;
            4'h9: return s ^ v;
            4'hA: return !(s ^ v);
            4'hB: return z || (s ^ v);
            4'hC: return !z && !(s ^ v);
            4'hD: return c || z;
            4'hE: return !c && !z;
            default: return 1'b0;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp,
                     $time);
        end
    endtask

    // Apply one cycle of stimulus, predict the response, advance the model.
    task automatic go(input bit v, input bit stall, input bit rst,
                      input bit [1:0] op, input bit [3:0] sel,
                      input bit [31:0] a, input bit [31:0] b,
                      input bit [31:0] pc, input bit [3:0] cc);
        exp_t e;
        longint ua, ub, sa, sb, u, s;
        bit cin, c, vf;
        bit [31:0] res;
        @(posedge clk);
        #1;
        reset        = rst;
        bus.v_i      = v;
        bus.stall_i  = stall;
        bus.op_i     = op;
        bus.select_i = sel;
        bus.opr0_i   = a;
        bus.opr1_i   = b;
        bus.pc_i     = pc;
        bus.cc_i     = cc;
        if (rst) m_flags = 4'h0;
        res = 32'h0; c = 0; vf = 0;
        ua = longint'(a); ub = longint'(b);
        sa = longint'($signed(a)); sb = longint'($signed(b));
        if (op == 2'b01) begin
            cin = sel[1] ? m_flags[0] : 1'b0;
            if (!sel[0]) begin
                u = ua + ub + longint'(cin);
                s = sa + sb + longint'(cin);
                c = (u >> 32) != 0;
            end else begin
                u = ua - ub - longint'(cin);
                s = sa - sb - longint'(cin);
                c = ua < ub + longint'(cin);
            end
            res = u[31:0];
            vf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        end else if (op == 2'b10) begin
            u = (sb < 0) ? -sb : sb;
            res = u[31:0];
            vf = (b == 32'h8000_0000);
        end
        e.res = res;
        e.fn = (op == 2'b01 || op == 2'b10)
             ? {vf, res[31], res == 32'h0, c} : 4'h0;
        e.fo = m_flags;
        e.br = v && !stall && op == 2'b11 && cond_of(cc, m_flags);
        e.ba = sel[0] ? pc + b : b;
        sb_q.push_back(e);
        if (!rst && v && !stall && (op == 2'b01 || op == 2'b10))
            m_flags = e.fn;
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("result",     bus.result_o,           e.res);
                chk("flags_next", {28'h0, bus.flags_next_o}, {28'h0, e.fn});
                chk("flags",      {28'h0, bus.flags_o},   {28'h0, e.fo});
                chk("branch",     {31'h0, bus.branch_o},  {31'h0, e.br});
                chk("branch_addr", bus.branch_addr_o,     e.ba);
            end
        end
    end

    function automatic bit [31:0] pick32();
        case ($urandom_range(0, 6))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            4: return 32'(($urandom_range(0, 8)));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int n;
        bus.v_i = 0; bus.stall_i = 0; bus.op_i = 0; bus.select_i = 0;
        bus.opr0_i = 0; bus.opr1_i = 0; bus.pc_i = 0; bus.cc_i = 0;
        go(0, 0, 1, 2'b00, 4'h0, 0, 0, 0, 4'h0);
        go(1, 0, 0, 2'b01, 4'h0, 32'hFFFF_FFFF, 32'h1, 0, 4'h0);
        go(1, 0, 0, 2'b01, 4'h0, 32'h7FFF_FFFF, 32'h1, 0, 4'h0);
        go(1, 0, 0, 2'b01, 4'h1, 32'd3, 32'd5, 0, 4'h0);
        go(1, 0, 0, 2'b01, 4'hB, 32'd10, 32'd2, 0, 4'h0);
        go(1, 0, 0, 2'b01, 4'h2, 32'd1, 32'd1, 0, 4'h0);
        go(1, 0, 0, 2'b10, 4'h0, 32'h1234, 32'hFFFF_FFFB, 0, 4'h0);
        go(1, 0, 0, 2'b10, 4'h0, 0, 32'h8000_0000, 0, 4'h0);
        go(1, 0, 0, 2'b10, 4'h0, 0, 32'h0, 0, 4'h0);
        go(1, 0, 0, 2'b01, 4'h1, 32'd5, 32'd5, 0, 4'h0);
        go(1, 0, 0, 2'b11, 4'h0, 0, 32'h100, 32'h40, 4'h1);
        go(1, 0, 0, 2'b11, 4'h0, 0, 32'h100, 32'h40, 4'h2);
        go(1, 0, 0, 2'b11, 4'h1, 0, 32'hFFFF_FFF0, 32'h1000, 4'h0);
        go(1, 0, 0, 2'b11, 4'h1, 0, 32'hFFFF_FFF0, 32'h1000, 4'hF);
        go(1, 1, 0, 2'b11, 4'h1, 0, 32'hFFFF_FFF0, 32'h1000, 4'h0);
        go(0, 0, 0, 2'b11, 4'h1, 0, 32'hFFFF_FFF0, 32'h1000, 4'h0);
        go(1, 0, 0, 2'b01, 4'h0, 32'hFFFF_FFFF, 32'h1, 0, 4'h0);
        go(1, 0, 1, 2'b00, 4'h0, 0, 0, 0, 4'h0);
        go(1, 0, 0, 2'b01, 4'h1, 32'd3, 32'd5, 0, 4'h0);
        go(1, 1, 0, 2'b01, 4'h0, 32'hFFFF_FFFF, 32'h1, 0, 4'h0);
        go(1, 0, 0, 2'b00, 4'h0, 0, 0, 0, 4'h0);
        for (int i = 0; i < 400; i++) begin
            go($urandom_range(0, 9) != 0, $urandom_range(0, 6) == 0,
               $urandom_range(0, 60) == 0, 2'($urandom_range(0, 3)),
               4'($urandom), pick32(), pick32(), $urandom,
               4'($urandom));
        end
        n = 0;
        while (sb_q.size() > 0 && n < 10) begin
            @(negedge clk);
            n++;
        end
        #1;
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
